// File: rtl/input_spike_encoder_if.sv
// Encoder-side bus: pixel memory read port, scheduler push port and step/sample control.
// Optional SPIKE_CNT signal is present only when ENC_SPIKE_CNT_EN is defined.
interface input_spike_encoder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int TS_W   = 3
);
  logic              START;
  logic              PIXEL_RD_EN;
  logic [ADDR_W-1:0] PIXEL_RD_ADDR;
  logic [DATA_W-1:0] PIXEL_RD_DATA;
  logic              SCHED_FULL;
  logic              CTRL_SCHED_EVENT_IN;
  logic [ADDR_W-1:0] CTRL_SCHED_ADDR;
  logic [1:0]        CTRL_SCHED_VIRTS;
  logic              CORE_TS_ACK;
  logic [TS_W-1:0]   TS_IDX;
  logic              TS_DONE;
  logic              ENC_BUSY;
  logic              ENC_DONE;
`ifdef ENC_SPIKE_CNT_EN
  logic [15:0]       SPIKE_CNT;
`endif

  modport master (
    input  START, PIXEL_RD_DATA, SCHED_FULL, CORE_TS_ACK,
    output PIXEL_RD_EN, PIXEL_RD_ADDR, CTRL_SCHED_EVENT_IN, CTRL_SCHED_ADDR,
           CTRL_SCHED_VIRTS, TS_IDX, TS_DONE, ENC_BUSY, ENC_DONE
`ifdef ENC_SPIKE_CNT_EN
    , output SPIKE_CNT
`endif
  );

  modport slave (
    output START, PIXEL_RD_DATA, SCHED_FULL, CORE_TS_ACK,
    input  PIXEL_RD_EN, PIXEL_RD_ADDR, CTRL_SCHED_EVENT_IN, CTRL_SCHED_ADDR,
           CTRL_SCHED_VIRTS, TS_IDX, TS_DONE, ENC_BUSY, ENC_DONE
`ifdef ENC_SPIKE_CNT_EN
    , input SPIKE_CNT
`endif
  );
endinterface

// File: rtl/input_spike_encoder.sv
// Rate-codes pixel intensities into AER spike events with a 16-bit Galois LFSR, one marker per step.
// Define ENC_SPIKE_CNT_EN to add the saturating SPIKE_CNT output.
module input_spike_encoder #(
  parameter int          TIME_STEP           = 8,
  parameter int          INPUT_NEURON        = 784,
  parameter int          PRE_NEUR_ADDR_WIDTH = 10,
  parameter int          PRE_NEUR_DATA_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input logic                   CLK,
  input logic                   RSTN,
  input_spike_encoder_if.master bus
);
  localparam int          AW         = PRE_NEUR_ADDR_WIDTH;
  localparam int          DW         = PRE_NEUR_DATA_WIDTH;
  localparam int          TS_W       = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  typedef enum logic [2:0] {IDLE, READ, CMP, EOT, WAIT_ACK} state_t;

  state_t          state_reg;
  logic [AW-1:0]   neuron_reg;
  logic [TS_W-1:0] ts_idx_reg;
  logic [15:0]     lfsr_reg;
  logic [15:0]     lfsr_next;
  logic [DW-1:0]   pix_reg;
  logic            cmp_first_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [DW-1:0]   pix_val;
  logic            spike;
  logic            spike_push;
  logic            eot_push;
  logic            cmp_stall;
  logic            last_neuron;
  logic            last_ts;

  // Right-shifting Galois step: feedback bit lfsr_reg[0] is XORed into the mask taps.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
      if (gi == 15) begin : g_top
        assign lfsr_next[gi] = LFSR_MASK[gi] & lfsr_reg[0];
      end else begin : g_mid
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
      end
    end
  endgenerate

  // Memory data is only live on the first CMP cycle; later stall cycles use the captured copy.
  assign pix_val     = cmp_first_reg ? bus.PIXEL_RD_DATA : pix_reg;
  assign spike       = pix_val > lfsr_reg[DW-1:0];
  assign cmp_stall   = (state_reg == CMP) && spike && bus.SCHED_FULL;
  assign spike_push  = (state_reg == CMP) && spike && !bus.SCHED_FULL;
  assign eot_push    = (state_reg == EOT) && !bus.SCHED_FULL;
  assign last_neuron = (neuron_reg == AW'(INPUT_NEURON - 1));
  assign last_ts     = (ts_idx_reg == TS_W'(TIME_STEP - 1));

  assign bus.PIXEL_RD_EN         = (state_reg == READ);
  assign bus.PIXEL_RD_ADDR       = (state_reg == READ) ? neuron_reg : '0;
  assign bus.CTRL_SCHED_EVENT_IN = spike_push || eot_push;
  assign bus.CTRL_SCHED_ADDR     = (state_reg == CMP) ? neuron_reg : '0;
  assign bus.CTRL_SCHED_VIRTS    = (state_reg == EOT) ? 2'b01 : 2'b00;
  assign bus.TS_IDX              = ts_idx_reg;
  assign bus.TS_DONE             = eot_push;
  assign bus.ENC_BUSY            = busy_reg;
  assign bus.ENC_DONE            = done_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= IDLE;
      neuron_reg    <= '0;
      ts_idx_reg    <= '0;
      lfsr_reg      <= LFSR_SEED;
      pix_reg       <= '0;
      cmp_first_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            state_reg  <= READ;
            neuron_reg <= '0;
            ts_idx_reg <= '0;
            lfsr_reg   <= LFSR_SEED;
            busy_reg   <= 1'b1;
          end
        end
        READ: begin
          state_reg     <= CMP;
          cmp_first_reg <= 1'b1;
        end
        CMP: begin
          cmp_first_reg <= 1'b0;
          if (cmp_first_reg) begin
            pix_reg <= bus.PIXEL_RD_DATA;
          end
          if (!cmp_stall) begin
            lfsr_reg <= lfsr_next;
            if (last_neuron) begin
              state_reg <= EOT;
            end else begin
              neuron_reg <= neuron_reg + AW'(1);
              state_reg  <= READ;
            end
          end
        end
        EOT: begin
          if (!bus.SCHED_FULL) begin
            state_reg <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.CORE_TS_ACK) begin
            if (last_ts) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              ts_idx_reg <= ts_idx_reg + TS_W'(1);
              neuron_reg <= '0;
              state_reg  <= READ;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ENC_SPIKE_CNT_EN
  logic [15:0] spike_cnt_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      spike_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && bus.START) begin
      spike_cnt_reg <= '0;
    end else if (spike_push && (spike_cnt_reg != 16'hFFFF)) begin
      spike_cnt_reg <= spike_cnt_reg + 16'd1;
    end
  end

  assign bus.SPIKE_CNT = spike_cnt_reg;
`endif
endmodule

// File: tb/tb_input_spike_encoder.sv
// Scoreboard bench: stimulus queues expected AER events from a reference LFSR model,
// a negedge monitor pops and compares every push the encoder makes.
module tb_input_spike_encoder;
  localparam int          N    = 784;
  localparam int          TS   = 8;
  localparam int          AW   = 10;
  localparam int          DW   = 8;
  localparam int          TSW  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [1:0]     virts;
    logic [TSW-1:0] ts;
  } ev_t;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  input_spike_encoder_if #(.ADDR_W(AW), .DATA_W(DW), .TS_W(TSW)) bus ();

  input_spike_encoder #(
    .TIME_STEP(TS), .INPUT_NEURON(N), .PRE_NEUR_ADDR_WIDTH(AW),
    .PRE_NEUR_DATA_WIDTH(DW), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .bus(bus)
  );

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  cyc          = 0;
  int  t0           = 0;
  bit  stalled      = 1'b0;
  bit  timing_en    = 1'b0;
  int  spikes_seen  = 0;
  int  markers_seen = 0;
  ev_t exp_q[$];
  logic [DW-1:0] pix [N];

  always @(posedge CLK) cyc <= cyc + 1;

  // Pixel memory: one-cycle read latency.
  always @(posedge CLK) begin
    if (bus.PIXEL_RD_EN) bus.PIXEL_RD_DATA <= pix[bus.PIXEL_RD_ADDR];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_summary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  task automatic timeout_abort(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL timeout %s: no DUT response at cycle %0d", name, cyc);
    finish_summary();
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic gen_events(input int nsteps, output int nspk);
    logic [15:0] l;
    l    = SEED;
    nspk = 0;
    for (int s = 0; s < nsteps; s++) begin
      for (int n = 0; n < N; n++) begin
        if (pix[n] > l[7:0]) begin
          exp_q.push_back('{AW'(n), 2'b00, TSW'(s)});
          nspk++;
        end
        l = lfsr_adv(l);
      end
      exp_q.push_back('{AW'(0), 2'b01, TSW'(s)});
    end
  endtask

  // Monitor: every push is popped against the scoreboard.
  always @(negedge CLK) begin
    ev_t e;
    ev_t got;
    if (RSTN) begin
      if (bus.SCHED_FULL) begin
        stalled = 1'b1;
        check("strobe_while_full", {31'd0, bus.CTRL_SCHED_EVENT_IN}, 32'd0);
      end
      if (bus.PIXEL_RD_EN && bus.PIXEL_RD_ADDR == '0) begin
        t0      = cyc;
        stalled = 1'b0;
      end
      if (bus.CTRL_SCHED_EVENT_IN) begin
        got = '{bus.CTRL_SCHED_ADDR, bus.CTRL_SCHED_VIRTS, bus.TS_IDX};
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_event: got addr=%0d virts=%0d ts=%0d, required none",
                   got.addr, got.virts, got.ts);
        end else begin
          e = exp_q.pop_front();
          check("event{addr,virts,ts}", 32'(got), 32'(e));
          if (got.virts == 2'b01) begin
            markers_seen++;
            check("ts_done_with_marker", {31'd0, bus.TS_DONE}, 32'd1);
            if (timing_en && !stalled) check("marker_cycle", 32'(cyc - t0 + 1), 32'd1569);
          end else begin
            spikes_seen++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ts_done();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k > 5000) timeout_abort("ts_done");
    end while (!bus.TS_DONE);
    tick();
  endtask

  task automatic wait_read(input int addr, input int ts);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k > 20000) timeout_abort("read_addr");
    end while (!(bus.PIXEL_RD_EN && bus.PIXEL_RD_ADDR == AW'(addr) && bus.TS_IDX == TSW'(ts)));
  endtask

  task automatic start_sample();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("busy_after_start", {31'd0, bus.ENC_BUSY}, 32'd1);
    check("ts_idx_after_start", {29'd0, bus.TS_IDX}, 32'd0);
  endtask

  task automatic run_steps(input int nsteps, input bit expect_done);
    for (int s = 0; s < nsteps; s++) begin
      wait_ts_done();
      repeat (4) tick();
      bus.CORE_TS_ACK = 1'b1;
      tick();
      bus.CORE_TS_ACK = 1'b0;
      if (expect_done && s == TS - 1) begin
        check("enc_done_after_last_ack", {31'd0, bus.ENC_DONE}, 32'd1);
        check("busy_cleared", {31'd0, bus.ENC_BUSY}, 32'd0);
        tick();
        check("enc_done_one_cycle", {31'd0, bus.ENC_DONE}, 32'd0);
      end else begin
        check("ts_idx_advance", {29'd0, bus.TS_IDX}, 32'(s + 1));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.PIXEL_RD_EN, bus.PIXEL_RD_ADDR, bus.CTRL_SCHED_EVENT_IN, bus.CTRL_SCHED_ADDR,
                 bus.CTRL_SCHED_VIRTS, bus.TS_IDX, bus.TS_DONE, bus.ENC_BUSY, bus.ENC_DONE}, 32'd0);
    check({name, "_lfsr"}, {16'd0, dut.lfsr_reg}, {16'd0, SEED});
  endtask

  // Disturbances applied while the sample runs: two stalls and a stray START.
  task automatic disturb_b();
    logic [15:0] l10;
    bit          spike10;
    l10 = SEED;
    for (int i = 0; i < 10; i++) l10 = lfsr_adv(l10);
    spike10 = (8'd255 > l10[7:0]);

    wait_read(10, 0);
    tick();
    bus.SCHED_FULL = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (spike10) begin
        check("stall_addr_stable", {22'd0, bus.CTRL_SCHED_ADDR}, 32'd10);
        check("stall_lfsr_held", {16'd0, dut.lfsr_reg}, {16'd0, l10});
      end
    end
    @(posedge CLK);
    #1;
    bus.SCHED_FULL = 1'b0;
    @(negedge CLK);
    if (spike10) check("stall_release_push", {21'd0, bus.CTRL_SCHED_EVENT_IN, bus.CTRL_SCHED_ADDR},
                       {21'd0, 1'b1, 10'd10});

    wait_read(N - 1, 1);
    tick();
    tick();
    bus.SCHED_FULL = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      check("eot_stall_no_ts_done", {31'd0, bus.TS_DONE}, 32'd0);
    end
    @(posedge CLK);
    #1;
    bus.SCHED_FULL = 1'b0;
    @(negedge CLK);
    check("eot_release_marker", {29'd0, bus.CTRL_SCHED_EVENT_IN, bus.CTRL_SCHED_VIRTS}, 32'b101);

    wait_read(5, 3);
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("start_ignored_busy", {31'd0, bus.ENC_BUSY}, 32'd1);
    check("start_ignored_ts", {29'd0, bus.TS_IDX}, 32'd3);
  endtask

  initial begin
    #600000;
    timeout_abort("global_watchdog");
  end

  initial begin
    int nspk;
    int spk0;
    int mk0;
    bus.START         = 1'b0;
    bus.SCHED_FULL    = 1'b0;
    bus.CORE_TS_ACK   = 1'b0;
    for (int n = 0; n < N; n++) pix[n] = 8'd0;

    repeat (3) tick();
    check_reset_outputs("reset_state");
    RSTN = 1'b1;
    tick();
    check_reset_outputs("idle_after_reset");

    // All-zero image: markers only.
    timing_en = 1'b1;
    spk0 = spikes_seen;
    mk0  = markers_seen;
    gen_events(TS, nspk);
    start_sample();
    run_steps(TS, 1'b1);
    check("zero_img_queue_drained", 32'(exp_q.size()), 32'd0);
    check("zero_img_spikes", 32'(spikes_seen - spk0), 32'd0);
    check("zero_img_markers", 32'(markers_seen - mk0), 32'd8);
`ifdef ENC_SPIKE_CNT_EN
    check("zero_img_spike_cnt", {16'd0, bus.SPIKE_CNT}, 32'd0);
`endif

    // All-255 image with stalls and a stray START.
    for (int n = 0; n < N; n++) pix[n] = 8'd255;
    spk0 = spikes_seen;
    gen_events(TS, nspk);
    start_sample();
    fork
      run_steps(TS, 1'b1);
      disturb_b();
    join
    check("full_img_queue_drained", 32'(exp_q.size()), 32'd0);
    check("full_img_spikes", 32'(spikes_seen - spk0), 32'(nspk));
`ifdef ENC_SPIKE_CNT_EN
    check("full_img_spike_cnt", {16'd0, bus.SPIKE_CNT}, 32'(nspk));
`endif

    // Only pixel 783 lit; reset at the start of step 5, then replay step 0.
    for (int n = 0; n < N; n++) pix[n] = 8'd0;
    pix[N-1] = 8'd128;
    gen_events(5, nspk);
    start_sample();
    run_steps(5, 1'b0);
    RSTN = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid_run_reset");
    check("pre_reset_queue_drained", 32'(exp_q.size()), 32'd0);
    tick();
    RSTN = 1'b1;
    tick();
    gen_events(1, nspk);
    start_sample();
    run_steps(1, 1'b0);
    check("replay_step0_drained", 32'(exp_q.size()), 32'd0);
    RSTN = 1'b0;
    tick();
    check_reset_outputs("final_reset");
    RSTN = 1'b1;
    tick();

    finish_summary();
  end
endmodule

// File: doc/input_spike_encoder.md
Name: input_spike_encoder

Overview:
- Upstream producer for the scheduler event FIFO.
- Reads 8-bit input pixel intensities from the pre-neuron memory and rate-codes them into Bernoulli spike events using an LFSR.
- Pushes one AER event per spike per time step into the scheduler, then pushes an end-of-timestep marker.
- Waits for the core to acknowledge each time step before starting the next, for TIME_STEP steps per sample.

Parameters:
- TIME_STEP, 8: time steps per sample.
- INPUT_NEURON, 784: pixels scanned per time step.
- PRE_NEUR_ADDR_WIDTH, 10: pixel/event address width.
- PRE_NEUR_DATA_WIDTH, 8: pixel width; also the width of the LFSR compare slice.
- LFSR_SEED, 16'hACE1: LFSR reset/reseed value; must be nonzero.

Ports:
- CLK  in  1  clock
- RSTN  in  1  async active-low reset
- START  in  1  one-cycle pulse; begins encoding a sample
- PIXEL_RD_EN  out  1  pixel memory read strobe
- PIXEL_RD_ADDR  out  PRE_NEUR_ADDR_WIDTH  pixel address
- PIXEL_RD_DATA  in  PRE_NEUR_DATA_WIDTH  pixel data, valid 1 cycle after PIXEL_RD_EN
- SCHED_FULL  in  1  scheduler FIFO full
- CTRL_SCHED_EVENT_IN  out  1  push strobe to scheduler
- CTRL_SCHED_ADDR  out  PRE_NEUR_ADDR_WIDTH  event neuron address
- CTRL_SCHED_VIRTS  out  2  event type: 2'b00 spike, 2'b01 end-of-timestep marker
- CORE_TS_ACK  in  1  one-cycle pulse; core finished current time step
- TS_IDX  out  $clog2(TIME_STEP)  current time step
- TS_DONE  out  1  one-cycle pulse when the marker is pushed
- ENC_BUSY  out  1  high from START acceptance until ENC_DONE
- ENC_DONE  out  1  one-cycle pulse after the last step is acknowledged

Behaviour:
- Reset: state IDLE; neuron counter, TS_IDX, PIXEL_RD_*, CTRL_SCHED_*, TS_DONE, ENC_BUSY, ENC_DONE all 0; LFSR = LFSR_SEED.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Advances exactly once per CMP evaluation that completes (spike pushed, or no spike).
  - Frozen during stalls.
  - Reloaded to LFSR_SEED on START acceptance.
- Spike rule: spike = PIXEL_RD_DATA > LFSR[7:0], unsigned strict compare. Pixel 0 never spikes.
- FSM:
  - IDLE: on START, go to READ with neuron=0, TS_IDX=0, ENC_BUSY=1. START in any other state is ignored.
  - READ: PIXEL_RD_EN=1 and PIXEL_RD_ADDR=neuron for this one cycle; go to CMP.
  - CMP: PIXEL_RD_DATA is captured into a register on the first CMP cycle and held through stalls.
    - No spike: advance LFSR.
    - Spike and !SCHED_FULL: CTRL_SCHED_EVENT_IN=1 combinationally, CTRL_SCHED_ADDR=neuron, VIRTS=00; advance LFSR.
    - Spike and SCHED_FULL: stay in CMP. Strobe low, address stable, LFSR held.
    - On completion: if neuron==INPUT_NEURON-1, go to EOT; else neuron+1 and go to READ.
  - EOT: when !SCHED_FULL, assert strobe with VIRTS=01, ADDR=0, pulse TS_DONE, go to WAIT_ACK. Stall while full.
  - WAIT_ACK: on CORE_TS_ACK:
    - If TS_IDX==TIME_STEP-1: pulse ENC_DONE, clear ENC_BUSY, go to IDLE.
    - Else: TS_IDX+1, neuron=0, go to READ.
  - CORE_TS_ACK is ignored outside WAIT_ACK.
- Strobe rule: CTRL_SCHED_EVENT_IN is never asserted while SCHED_FULL=1, so no event is ever dropped.
- Throughput: 2 cycles per neuron unstalled. The marker pushes in cycle 2*INPUT_NEURON+1 after entering the step's first READ.
- Reset mid-operation: immediate return to reset values. Partial events already in the FIFO are not retracted.

Optional Feature:
- Macro ENC_SPIKE_CNT_EN.
- When defined:
  - Adds output SPIKE_CNT [15:0]: count of spike events (VIRTS=00) pushed.
  - Cleared on START acceptance and reset.
  - Saturates at 16'hFFFF; holds its value after ENC_DONE.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- All pixels 0, START, ack each TS_DONE 5 cycles later -> zero spike pushes, exactly 8 markers (VIRTS=01). TS_IDX steps 0..7. ENC_DONE on the cycle after the 8th ack. SPIKE_CNT=0.
- All pixels 255, SCHED_FULL=0 -> spike count per step equals the reference-model count of LFSR bytes !=255. Event addresses ascend 0..783. Marker at cycle 1569 of each step.
- Pixel[783]=128, others 0 -> events only at ADDR 783. The per-step spike pattern matches the LFSR model from seed 16'hACE1.
- Hold SCHED_FULL=1 for 20 cycles while CMP has a spike at neuron 10 -> no strobe for 20 cycles, ADDR=10 stable, LFSR unchanged. Exactly one push of 10 follows when full drops. Same check for the EOT marker.
- START pulsed again during step 3 -> ignored; sequence unchanged. RSTN low during step 5 -> all outputs 0, LFSR=16'hACE1. A new START reproduces the step-0 event stream identically.
- ENC_SPIKE_CNT_EN defined with all pixels 255 -> SPIKE_CNT equals the total number of VIRTS=00 pushes.
